// File: rtl/uart_reg_bridge_if.sv
// Bundle of RX/TX FIFO handshakes, register bus and error flag seen by the
// UART register bridge. The master side is the bridge itself.
interface uart_reg_bridge_if;
   logic [7:0] rx_data;
   logic       rx_empty;
   logic       rx_rd;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       tx_full;
   logic [7:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_we;
   logic       bus_re;
   logic [7:0] bus_rdata;
   logic       proto_err;

   modport master (
      input  rx_data, rx_empty, tx_full, bus_rdata,
      output rx_rd, tx_data, tx_wr, bus_addr, bus_wdata, bus_we, bus_re, proto_err
   );

   modport slave (
      output rx_data, rx_empty, tx_full, bus_rdata,
      input  rx_rd, tx_data, tx_wr, bus_addr, bus_wdata, bus_we, bus_re, proto_err
   );
endinterface

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: parses 'W' addr data / 'R' addr commands from the RX FIFO,
// performs one register-bus access and pushes a single reply byte to the TX
// FIFO. Unknown opcodes reply '?'; a stalled partial command is dropped.
module uart_reg_bridge #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd100000
) (
   input logic               CLK,
   input logic               rst_n,
   uart_reg_bridge_if.master u
);
   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] OP_RD   = 8'h52;
   localparam logic [7:0] RPL_OK  = 8'h4B;
   localparam logic [7:0] RPL_BAD = 8'h3F;

   typedef enum logic [2:0] {
      IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND
   } state_t;

   state_t      state_q;
   logic        gap_q;
   logic        op_wr_q;
   logic [23:0] cnt_q;
   logic [7:0]  addr_q, wdata_q, txd_q;
   logic        we_q, re_q, perr_q;

   logic        waiting;
   logic        rx_take;
   logic        tmo;
   logic [23:0] cnt_inc;

   // Byte pops are combinational so the FWFT head is captured in the pop cycle;
   // the cycle after a pop is skipped to let the FIFO flags settle.
   assign waiting = (state_q == GET_ADDR) || (state_q == GET_DATA);
   assign rx_take = rst_n && !gap_q && !u.rx_empty && (waiting || (state_q == IDLE));
   assign cnt_inc = (cnt_q == 24'hFF_FFFF) ? cnt_q : cnt_q + 24'd1;
   // Expiry is flagged in the cycle the counter reaches the limit; a byte
   // arriving in that same cycle takes priority.
   assign tmo     = rst_n && waiting && !rx_take && (cnt_inc >= TIMEOUT_CYCLES);

   assign u.rx_rd     = rx_take;
   assign u.tx_wr     = rst_n && (state_q == SEND) && !u.tx_full;
   assign u.tx_data   = txd_q;
   assign u.bus_addr  = addr_q;
   assign u.bus_wdata = wdata_q;
   assign u.bus_we    = we_q;
   assign u.bus_re    = re_q;
   assign u.proto_err = perr_q | tmo;

   // Command FSM with inter-byte timeout and registered bus/reply outputs
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gap_q   <= 1'b0;
         op_wr_q <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         txd_q   <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         re_q   <= 1'b0;
         perr_q <= 1'b0;
         gap_q  <= rx_take;
         if (rx_take)      cnt_q <= '0;
         else if (waiting) cnt_q <= cnt_inc;

         unique case (state_q)
            IDLE: begin
               if (rx_take) begin
                  if (u.rx_data == OP_WR || u.rx_data == OP_RD) begin
                     op_wr_q <= (u.rx_data == OP_WR);
                     state_q <= GET_ADDR;
                  end else begin
                     txd_q   <= RPL_BAD;
                     perr_q  <= 1'b1;
                     state_q <= SEND;
                  end
               end
            end
            GET_ADDR: begin
               if (tmo) begin
                  state_q <= IDLE;
               end else if (rx_take) begin
                  addr_q <= u.rx_data;
                  if (op_wr_q) begin
                     state_q <= GET_DATA;
                  end else begin
                     re_q    <= 1'b1;
                     state_q <= BUS_RD;
                  end
               end
            end
            GET_DATA: begin
               if (tmo) begin
                  state_q <= IDLE;
               end else if (rx_take) begin
                  wdata_q <= u.rx_data;
                  we_q    <= 1'b1;
                  state_q <= BUS_WR;
               end
            end
            BUS_WR: begin
               txd_q   <= RPL_OK;
               state_q <= SEND;
            end
            BUS_RD: begin
               state_q <= RD_WAIT;
            end
            RD_WAIT: begin
               txd_q   <= u.bus_rdata;
               state_q <= SEND;
            end
            SEND: begin
               if (!u.tx_full) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: emulates the RX FIFO, TX FIFO flag and a register
// file, compares every cycle against a transaction-timing model, and pins the
// model with hand-computed literals for each directed scenario.
module tb_uart_reg_bridge;
   localparam int TMO = 50;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_reg_bridge_if u();
   uart_reg_bridge #(.TIMEOUT_CYCLES(24'd50)) dut (.CLK(clk), .rst_n(rst_n), .u(u));

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   logic [7:0] fifo[$];
   logic [7:0] mem_env[256];

   // model state: when things are due, expressed as absolute cycle numbers
   logic [7:0] m_mem[256];
   logic [7:0] m_cmd[$];
   int         m_free, m_last, m_we_at, m_re_at, m_perr_at, m_tx_from;
   bit         m_tx_pend;
   logic [7:0] m_tx_b, m_wa, m_wd;

   // observed DUT events
   int         n_pop = 0, n_we = 0, n_re = 0, n_perr = 0;
   int         last_pop = 0, last_we = 0, last_re = 0, last_perr = 0;
   logic [7:0] tx_b[$];
   int         tx_c[$];
   bit         back2back = 0, prev_pop = 0, post_rst = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
   endtask

   task automatic pins();
      u.rx_empty = (fifo.size() == 0);
      u.rx_data  = (fifo.size() != 0) ? fifo[0] : 8'hEE;
   endtask

   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
      pins();
   endtask

   task automatic model_reset();
      m_cmd.delete();
      m_tx_pend = 0;
      m_we_at   = -1;
      m_re_at   = -1;
      m_perr_at = -1;
      m_free    = cyc + 1;
      m_last    = 0;
   endtask

   task automatic model_step();
      bit e_pop, e_tx, e_perr;
      logic [7:0] b;
      e_tx   = m_tx_pend && cyc >= m_tx_from && !u.tx_full;
      e_pop  = !m_tx_pend && cyc >= m_free && fifo.size() != 0;
      e_perr = (cyc == m_perr_at);
      if (cyc == m_we_at) begin
         chk("bus_addr_wr", 32'(u.bus_addr), 32'(m_wa));
         chk("bus_wdata", 32'(u.bus_wdata), 32'(m_wd));
      end
      if (!e_pop && m_cmd.size() != 0 && cyc - m_last >= TMO) begin
         e_perr = 1;
         m_cmd.delete();
         if (m_free < cyc + 1) m_free = cyc + 1;
      end
      if (e_pop) begin
         b = fifo[0];
         m_cmd.push_back(b);
         m_last = cyc;
         m_free = cyc + 2;
         if (m_cmd.size() == 1 && b != 8'h57 && b != 8'h52) begin
            m_tx_pend = 1; m_tx_from = cyc + 1; m_tx_b = 8'h3F; m_perr_at = cyc + 1;
            m_cmd.delete();
         end else if (m_cmd.size() == 2 && m_cmd[0] == 8'h52) begin
            m_re_at = cyc + 1;
            m_tx_pend = 1; m_tx_from = cyc + 3; m_tx_b = m_mem[b];
            m_cmd.delete();
         end else if (m_cmd.size() == 3) begin
            m_we_at = cyc + 1; m_wa = m_cmd[1]; m_wd = b; m_mem[m_cmd[1]] = b;
            m_tx_pend = 1; m_tx_from = cyc + 2; m_tx_b = 8'h4B;
            m_cmd.delete();
         end
      end
      if (e_tx) begin
         chk("tx_data", 32'(u.tx_data), 32'(m_tx_b));
         m_tx_pend = 0;
         if (m_free < cyc + 1) m_free = cyc + 1;
      end
      chk("rx_rd", 32'(u.rx_rd), 32'(e_pop));
      chk("tx_wr", 32'(u.tx_wr), 32'(e_tx));
      chk("proto_err", 32'(u.proto_err), 32'(e_perr));
      chk("bus_we", 32'(u.bus_we), 32'(cyc == m_we_at));
      chk("bus_re", 32'(u.bus_re), 32'(cyc == m_re_at));
   endtask

   task automatic tick();
      logic p, we, re;
      logic [7:0] a, wd;
      @(negedge clk);
      if (post_rst) begin
         chk("rst_ctrl", 32'({u.rx_rd, u.tx_wr, u.bus_we, u.bus_re, u.proto_err}), 32'd0);
         chk("rst_tx_data", 32'(u.tx_data), 32'd0);
         chk("rst_bus_addr", 32'(u.bus_addr), 32'd0);
         chk("rst_bus_wdata", 32'(u.bus_wdata), 32'd0);
         post_rst = 0;
      end
      if (!rst_n) model_reset();
      else        model_step();
      p  = u.rx_rd;
      we = u.bus_we;
      re = u.bus_re;
      a  = u.bus_addr;
      wd = u.bus_wdata;
      if (p === 1'b1) begin
         n_pop++;
         if (prev_pop) back2back = 1;
         last_pop = cyc;
      end
      prev_pop = (p === 1'b1);
      if (we === 1'b1) begin n_we++; last_we = cyc; end
      if (re === 1'b1) begin n_re++; last_re = cyc; end
      if (u.proto_err === 1'b1) begin n_perr++; last_perr = cyc; end
      if (u.tx_wr === 1'b1) begin tx_b.push_back(u.tx_data); tx_c.push_back(cyc); end
      @(posedge clk);
      #1;
      if (p === 1'b1 && fifo.size() != 0) void'(fifo.pop_front());
      if (we === 1'b1) mem_env[a] = wd;
      u.bus_rdata = (re === 1'b1) ? mem_env[a] : 8'hEE;
      pins();
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int i0, p0, we0, re0, pe0, crel;
      for (int k = 0; k < 256; k++) begin mem_env[k] = 8'h00; m_mem[k] = 8'h00; end
      mem_env[8'h22] = 8'h3C; m_mem[8'h22] = 8'h3C;
      mem_env[8'h05] = 8'h77; m_mem[8'h05] = 8'h77;
      mem_env[8'h01] = 8'h12; m_mem[8'h01] = 8'h12;
      u.tx_full = 1'b0;
      u.bus_rdata = 8'hEE;
      pins();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      post_rst = 1;
      run(3);

      // write 0x10 <= 0xA5
      i0 = tx_b.size(); p0 = n_pop; we0 = n_we;
      push(8'h57); push(8'h10); push(8'hA5);
      run(12);
      chk("wr_we_count", 32'(n_we - we0), 32'd1);
      chk("wr_pop_count", 32'(n_pop - p0), 32'd3);
      chk("wr_no_b2b_pop", 32'(back2back), 32'd0);
      chk("wr_tx_count", 32'(tx_b.size() - i0), 32'd1);
      chk("wr_reply", 32'(tx_b[i0]), 32'h4B);
      chk("wr_we_lat", 32'(last_we - last_pop), 32'd1);
      chk("wr_tx_lat", 32'(tx_c[i0] - last_pop), 32'd2);
      chk("wr_mem", 32'(mem_env[8'h10]), 32'hA5);

      // read 0x22 -> 0x3C
      i0 = tx_b.size(); re0 = n_re;
      push(8'h52); push(8'h22);
      run(10);
      chk("rd_re_count", 32'(n_re - re0), 32'd1);
      chk("rd_re_lat", 32'(last_re - last_pop), 32'd1);
      chk("rd_tx_lat", 32'(tx_c[i0] - last_pop), 32'd3);
      chk("rd_reply", 32'(tx_b[i0]), 32'h3C);

      // unknown opcode then back-to-back read of 0x05
      i0 = tx_b.size(); pe0 = n_perr;
      push(8'h41); push(8'h52); push(8'h05);
      run(16);
      chk("unk_tx_count", 32'(tx_b.size() - i0), 32'd2);
      chk("unk_reply", 32'(tx_b[i0]), 32'h3F);
      chk("unk_then_rd", 32'(tx_b[i0+1]), 32'h77);
      chk("unk_perr_count", 32'(n_perr - pe0), 32'd1);
      chk("unk_perr_with_tx", 32'(last_perr), 32'(tx_c[i0]));

      // timeout after 'W', addr
      i0 = tx_b.size(); pe0 = n_perr; we0 = n_we;
      push(8'h57); push(8'h10);
      run(70);
      chk("tmo_perr_count", 32'(n_perr - pe0), 32'd1);
      chk("tmo_lat", 32'(last_perr - last_pop), 32'd50);
      chk("tmo_no_we", 32'(n_we - we0), 32'd0);
      chk("tmo_no_tx", 32'(tx_b.size() - i0), 32'd0);
      push(8'h52); push(8'h01);
      run(10);
      chk("tmo_next_rd", 32'(tx_b[tx_b.size()-1]), 32'h12);

      // backpressure during write reply, a read queued behind it
      i0 = tx_b.size(); p0 = n_pop;
      u.tx_full = 1'b1;
      push(8'h57); push(8'h10); push(8'hA5);
      run(10);
      push(8'h52); push(8'h10);
      run(190);
      chk("bp_pops_held", 32'(n_pop - p0), 32'd3);
      chk("bp_no_tx", 32'(tx_b.size() - i0), 32'd0);
      u.tx_full = 1'b0;
      crel = cyc;
      run(12);
      chk("bp_tx_first_free", 32'(tx_c[i0]), 32'(crel));
      chk("bp_reply", 32'(tx_b[i0]), 32'h4B);
      chk("bp_then_rd", 32'(tx_b[i0+1]), 32'hA5);

      // reset in the middle of a write
      push(8'h57); push(8'h10);
      run(5);
      i0 = tx_b.size(); pe0 = n_perr; we0 = n_we; re0 = n_re;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      post_rst = 1;
      run(60);
      chk("rst_no_perr", 32'(n_perr - pe0), 32'd0);
      chk("rst_no_tx", 32'(tx_b.size() - i0), 32'd0);
      chk("rst_no_we", 32'(n_we - we0), 32'd0);
      push(8'h52); push(8'h10);
      run(10);
      chk("rst_rd_count", 32'(n_re - re0), 32'd1);
      chk("rst_rd_reply", 32'(tx_b[tx_b.size()-1]), 32'hA5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
